fetch_unit: RTL and testbench

- Instruction-fetch stage of the KGP-RISC datapath; owns the program-counter register.
- Accepts the 32-bit next-PC chosen by the branch/sequential 2:1 select (redirect path).
- Issues one request at a time to instruction memory and holds the fetched word for decode.
- Decode consumes it through a valid/ready handshake.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one request at a
// time to instruction memory and holds the fetched word for decode.
//
// Handshake: decode sees instr/instr_pc when instr_valid=1. A transfer happens
// on a rising edge where instr_valid=1 and instr_ready=1 (and no redirect). While
// instr_valid=1 and instr_ready=0, instr/instr_pc/instr_valid are held stable.
// Memory side: imem_req is high for the whole wait; the word is taken on the
// edge where imem_req=1 and imem_ack=1.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] fetch_pc,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        halt_pend;

    // A redirect counts only outside HALT; HALT is left by rst alone.
    logic        redir_act;
    logic        stop_req;

    assign redir_act = redirect && (state != S_HALT);
    assign stop_req  = halt || halt_pend;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; redirect outranks ack, handshake and halt.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (redir_act)     state_nxt = S_IDLE;
                else if (stop_req) state_nxt = S_HALT;
                else               state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redir_act)     state_nxt = S_IDLE;
                else if (imem_ack) state_nxt = S_OUT;
            end
            S_OUT: begin
                if (redir_act)        state_nxt = S_IDLE;
                else if (instr_ready) state_nxt = stop_req ? S_HALT : S_REQ;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        imem_req  = (state == S_REQ);
        halted    = (state == S_HALT);
        dbg_state = state;
    end

    assign imem_addr = pc;
    assign fetch_pc  = pc;

    // PC, fetched word and valid flag. Redirect masks the low two bits of the
    // target and squashes both a coincident ack and a coincident handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else if (redir_act) begin
            pc          <= redirect_pc & ~32'h3;
            instr_valid <= 1'b0;
        end else if (state == S_REQ && imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc + STEP;
            instr_valid <= 1'b1;
        end else if (state == S_OUT && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    // Halt request is remembered until rst so an in-flight fetch can finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_pend <= 1'b0;
        end else if (halt && state != S_HALT) begin
            halt_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of the fetch stage followed by a randomized
// run against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;

    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, instr_pc, fetch_pc;
    logic [1:0]  dbg_state;

    logic        w_imem_req, w_instr_valid, w_halted;
    logic [31:0] w_imem_addr, w_instr, w_instr_pc, w_fetch_pc;
    logic [1:0]  w_dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model state for the randomized run.
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] m_pc;
    logic        m_bubble;
    logic        m_req;
    logic [31:0] r1, r2;

    // Clock.
    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .fetch_pc(fetch_pc), .halted(halted), .dbg_state(dbg_state)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst(rst), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(w_instr_valid),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready),
        .fetch_pc(w_fetch_pc), .halted(w_halted), .dbg_state(w_dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        r1 = $urandom; r2 = $urandom;

        // Reset for two edges.
        tick(); tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_halted", halted, 0);
        chk("rst_wrap_pc", w_fetch_pc, 32'hFFFF_FFFC);

        // Basic fetch: bubble, then request at 0, ack immediately.
        rst = 1'b0;
        tick();
        chk("b_req", imem_req, 1);
        chk("b_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("b_valid", instr_valid, 1);
        chk("b_instr", instr, 32'h1234_5678);
        chk("b_instr_pc", instr_pc, 32'h0);

        // Backpressure for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", instr_valid, 1);
            chk("bp_instr", instr, 32'h1234_5678);
            chk("bp_instr_pc", instr_pc, 32'h0);
            chk("bp_req", imem_req, 0);
            chk("bp_fetch_pc", fetch_pc, 32'h4);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp_rel_valid", instr_valid, 0);
        chk("bp_rel_req", imem_req, 1);
        chk("bp_rel_addr", imem_addr, 32'h4);

        // Redirect with coincident ack in REQ.
        redirect = 1'b1; redirect_pc = 32'h100;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("rd_instr", instr, 32'h1234_5678);
        chk("rd_valid", instr_valid, 0);
        chk("rd_bubble", imem_req, 0);
        chk("rd_pc", fetch_pc, 32'h100);
        tick();
        chk("rd_req", imem_req, 1);
        chk("rd_addr", imem_addr, 32'h100);

        // Misaligned redirect while holding in OUT.
        imem_ack = 1'b1; imem_rdata = r1;
        tick();
        imem_ack = 1'b0;
        chk("ma_valid", instr_valid, 1);
        chk("ma_instr", instr, r1);
        chk("ma_instr_pc", instr_pc, 32'h100);
        chk("ma_pc", fetch_pc, 32'h104);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("ma_valid_sq", instr_valid, 0);
        chk("ma_bubble", imem_req, 0);
        chk("ma_pc_mask", fetch_pc, 32'h100);
        tick();
        chk("ma_req", imem_req, 1);
        chk("ma_addr", imem_addr, 32'h100);

        // Halt pulse in REQ; ack two cycles later; delivery then HALT.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("h_req_hold", imem_req, 1);
        chk("h_not_halted", halted, 0);
        tick();
        imem_ack = 1'b1; imem_rdata = r2;
        tick();
        imem_ack = 1'b0;
        chk("h_valid", instr_valid, 1);
        chk("h_instr", instr, r2);
        chk("h_instr_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("h_halted", halted, 1);
        chk("h_valid_off", instr_valid, 0);
        redirect = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            redirect_pc = $urandom;
            tick();
            chk("h_req_off", imem_req, 0);
            chk("h_sticky", halted, 1);
            chk("h_pc_frozen", fetch_pc, 32'h104);
            chk("h_valid_stay", instr_valid, 0);
        end
        redirect = 1'b0; imem_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hr_halted", halted, 0);
        chk("hr_pc", fetch_pc, 32'h0);
        chk("hr_req", imem_req, 0);

        // Halt together with redirect: no further request, then HALT.
        tick();
        chk("hr2_req", imem_req, 1);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        halt = 1'b0; redirect = 1'b0;
        chk("hrd_pc", fetch_pc, 32'h200);
        chk("hrd_req", imem_req, 0);
        chk("hrd_halted", halted, 0);
        tick();
        chk("hrd_halt", halted, 1);
        chk("hrd_req2", imem_req, 0);
        tick();
        chk("hrd_req3", imem_req, 0);

        // Halt in IDLE.
        rst = 1'b1;
        tick();
        rst = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("hi_halted", halted, 1);
        chk("hi_req", imem_req, 0);

        // Wrap (second instance) and reset in the middle of a request.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("w_addr0", w_imem_addr, 32'hFFFF_FFFC);
        chk("w_req0", w_imem_req, 1);
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1;
        chk("w_instr_pc0", w_instr_pc, 32'hFFFF_FFFC);
        chk("w_pc_wrapped", w_fetch_pc, 32'h0);
        tick();
        instr_ready = 1'b0;
        chk("w_req1", w_imem_req, 1);
        chk("w_addr1", w_imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1;
        chk("w_instr_pc1", w_instr_pc, 32'h0);
        chk("w_fetch_pc1", w_fetch_pc, 32'h4);
        tick();
        instr_ready = 1'b0;
        chk("mr_req_before", imem_req, 1);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
        tick();
        rst = 1'b0; imem_ack = 1'b0;
        chk("mr_req", imem_req, 0);
        chk("mr_valid", instr_valid, 0);
        chk("mr_instr", instr, 32'h0);
        chk("mr_instr_pc", instr_pc, 32'h0);
        chk("mr_pc", fetch_pc, 32'h0);

        // Randomized run: state is IDLE at pc 0 after the reset above.
        m_pc = 32'h0;
        m_bubble = 1'b1;
        exp_q.delete();
        exp_pc_q.delete();
        for (int i = 0; i < 600; i++) begin
            m_req = (exp_q.size() == 0) && !m_bubble;
            chk("r_fetch_pc", fetch_pc, m_pc);
            chk("r_req", imem_req, m_req);
            chk("r_valid", instr_valid, exp_q.size() != 0);
            chk("r_halted", halted, 0);
            if (m_req) chk("r_addr", imem_addr, m_pc);
            if (exp_q.size() != 0) begin
                chk("r_instr", instr, exp_q[0]);
                chk("r_instr_pc", instr_pc, exp_pc_q[0]);
            end
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            imem_ack    = $urandom_range(0, 1) == 1;
            imem_rdata  = $urandom;
            instr_ready = $urandom_range(0, 1) == 1;
            if (redirect) begin
                m_pc = {redirect_pc[31:2], 2'b00};
                exp_q.delete();
                exp_pc_q.delete();
                m_bubble = 1'b1;
            end else begin
                m_bubble = 1'b0;
                if (m_req && imem_ack) begin
                    exp_q.push_back(imem_rdata);
                    exp_pc_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end else if (exp_q.size() != 0 && instr_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_pc_q.pop_front());
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
